// File: rtl/sprite_pkg.sv
// Shared types and constants for the Koopa sprite-sheet controller.
// The sheet holds 6 frames of 30x23 pixels stored back to back, so frame k
// starts at k*690 in the ROM.
package sprite_pkg;

   typedef enum logic [1:0] {IDLE, WALK, JUMP, ATTACK} anim_state_t;

   localparam int FRAME_W    = 30;
   localparam int FRAME_H    = 23;
   localparam int FRAME_SIZE = FRAME_W * FRAME_H;
   localparam int NUM_FRAMES = 6;

   localparam logic [2:0] FR_IDLE   = 3'd0;
   localparam logic [2:0] FR_WALK_A = 3'd1;
   localparam logic [2:0] FR_WALK_B = 3'd2;
   localparam logic [2:0] FR_JUMP   = 3'd3;
   localparam logic [2:0] FR_ATK_A  = 3'd4;
   localparam logic [2:0] FR_ATK_B  = 3'd5;

   // Padded to 8 entries so a 3-bit frame index always lands in range.
   // Slots 6 and 7 are never selected.
   localparam logic [12:0] FRAME_BASE [0:7] = '{
      13'd0, 13'd690, 13'd1380, 13'd2070, 13'd2760, 13'd3450, 13'd0, 13'd0
   };

   // First frame shown when a state is entered.
   function automatic logic [2:0] entry_frame(input anim_state_t s);
      case (s)
         WALK:    entry_frame = FR_WALK_A;
         JUMP:    entry_frame = FR_JUMP;
         ATTACK:  entry_frame = FR_ATK_A;
         default: entry_frame = FR_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator.
// Tests whether the current VGA pixel falls inside the sprite box, mirrors the
// column when facing left, and registers the ROM address. A 2-deep valid
// pipeline makes pix_valid line up with the ROM's registered rgb output.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   frame_idx            sheet frame selecting the base address
//   facing               1 = mirror horizontally
//   sprite_x/sprite_y    sprite top-left
//   draw_x/draw_y        current VGA pixel
//   rom_addr             registered ROM address (0 on miss)
//   pix_valid            hit flag delayed to match ROM data
module sprite_addr_gen #(
   parameter int FRAME_W = 30,
   parameter int FRAME_H = 23
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  frame_idx,
   input  logic        facing,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   output logic [12:0] rom_addr,
   output logic        pix_valid
);
   import sprite_pkg::*;

   localparam logic [9:0] W10      = 10'(FRAME_W);
   localparam logic [9:0] H10      = 10'(FRAME_H);
   localparam logic [9:0] LAST_COL = 10'(FRAME_W - 1);

   logic [9:0]  dx, dy, col10;
   logic [12:0] dy13, row_off, rom_addr_d, rom_addr_q;
   logic        hit;
   logic [1:0]  vld_pipe_d, vld_pipe_q;

   always_comb begin
      // Modulo-1024 offsets: pixels left of / above the sprite wrap to large
      // values and fail the unsigned range test, so no sign handling needed.
      dx    = draw_x - sprite_x;
      dy    = draw_y - sprite_y;
      hit   = (dx < W10) && (dy < H10);
      col10 = facing ? (LAST_COL - dx) : dx;
      dy13  = {3'b000, dy};
      // dy*30 as two shifts and a subtract
      row_off    = (dy13 << 5) - (dy13 << 1);
      rom_addr_d = hit ? (FRAME_BASE[frame_idx] + row_off + {3'b000, col10}) : '0;
      vld_pipe_d = {vld_pipe_q[0], hit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q <= '0;
         vld_pipe_q <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign pix_valid = vld_pipe_q[1];

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Koopa sprite animation controller.
// Chooses the animation state/frame from player inputs once per video frame
// and feeds the address generator that drives the sprite ROM.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   frame_tick                 one pulse per video frame; all state updates here
//   move_req/airborne/attack_req/facing_left   player state, sampled on tick
//   sprite_x/sprite_y          sprite top-left
//   draw_x/draw_y              current VGA pixel
//   rom_addr                   registered ROM address
//   pix_valid                  sprite covers the pixel the ROM presents now
//   frame_idx                  current sheet frame 0..5
//   busy                       attack animation running
module sprite_anim_ctrl #(
   parameter int FRAME_W        = 30,
   parameter int FRAME_H        = 23,
   parameter int TICKS_PER_STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        move_req,
   input  logic        airborne,
   input  logic        attack_req,
   input  logic        facing_left,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   output logic [12:0] rom_addr,
   output logic        pix_valid,
   output logic [2:0]  frame_idx,
   output logic        busy
);
   import sprite_pkg::*;

   localparam int STEP_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TICKS_PER_STEP - 1);

   anim_state_t       state_q, state_d, pick;
   logic [2:0]        frame_q, frame_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              facing_q, facing_d;
   logic              step_wrap, atk_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         frame_q  <= FR_IDLE;
         step_q   <= '0;
         facing_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         step_q   <= step_d;
         facing_q <= facing_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      step_d    = step_q;
      facing_d  = facing_q;
      step_wrap = (step_q == STEP_LAST);
      atk_done  = (frame_q == FR_ATK_B) && step_wrap;

      if (attack_req)    pick = ATTACK;
      else if (airborne) pick = JUMP;
      else if (move_req) pick = WALK;
      else               pick = IDLE;

      if (frame_tick) begin
         facing_d = facing_left;
         if ((state_q == ATTACK) && !atk_done) begin
            // Attack is one-shot: inputs are ignored until frame 5 finishes.
            if (step_wrap) begin
               step_d  = '0;
               frame_d = FR_ATK_B;
            end else begin
               step_d  = step_q + 1'b1;
            end
         end else if ((pick != state_q) || (state_q == ATTACK)) begin
            // Leaving a finished attack always restarts, even back into ATTACK.
            state_d = pick;
            step_d  = '0;
            frame_d = entry_frame(pick);
         end else if (step_wrap) begin
            step_d = '0;
            if (state_q == WALK)
               frame_d = (frame_q == FR_WALK_A) ? FR_WALK_B : FR_WALK_A;
         end else begin
            step_d = step_q + 1'b1;
         end
      end
   end

   assign frame_idx = frame_q;
   assign busy      = (state_q == ATTACK);

   sprite_addr_gen #(
      .FRAME_W (FRAME_W),
      .FRAME_H (FRAME_H)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_idx (frame_q),
      .facing    (facing_q),
      .sprite_x  (sprite_x),
      .sprite_y  (sprite_y),
      .draw_x    (draw_x),
      .draw_y    (draw_y),
      .rom_addr  (rom_addr),
      .pix_valid (pix_valid)
   );

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
module tb_sprite_anim_ctrl;

   logic        clk, rst_n, frame_tick, move_req, airborne, attack_req, facing_left;
   logic [9:0]  sprite_x, sprite_y, draw_x, draw_y;
   logic [12:0] rom_addr;
   logic        pix_valid, busy;
   logic [2:0]  frame_idx;

   int n_chk = 0;
   int n_pass = 0;

   // Behavioural model: mode 0 idle, 1 walk, 2 jump, 3 attack; m_ticks counts
   // frame ticks since the mode was entered.
   int m_mode = 0, m_ticks = 0, m_facing = 0;
   int m_addr = 0, m_v1 = 0, m_pv = 0;

   sprite_anim_ctrl #(.FRAME_W(30), .FRAME_H(23), .TICKS_PER_STEP(8)) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .move_req(move_req),
      .airborne(airborne), .attack_req(attack_req), .facing_left(facing_left),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .draw_x(draw_x), .draw_y(draw_y),
      .rom_addr(rom_addr), .pix_valid(pix_valid), .frame_idx(frame_idx), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int m_frame();
      case (m_mode)
         1:       return 1 + ((m_ticks / 8) % 2);
         2:       return 3;
         3:       return (m_ticks < 8) ? 4 : 5;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // model update
   initial begin
      int dx, dy, pick;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_mode = 0; m_ticks = 0; m_facing = 0;
            m_addr = 0; m_v1 = 0; m_pv = 0;
         end else begin
            dx = (int'(draw_x) - int'(sprite_x)) & 1023;
            dy = (int'(draw_y) - int'(sprite_y)) & 1023;
            m_pv = m_v1;
            m_v1 = (dx < 30 && dy < 23) ? 1 : 0;
            m_addr = m_v1 ? (m_frame() * 690 + dy * 30 + (m_facing ? 29 - dx : dx)) : 0;
            if (frame_tick) begin
               m_facing = facing_left ? 1 : 0;
               if (m_mode == 3 && m_ticks + 1 < 16) begin
                  m_ticks++;
               end else begin
                  pick = attack_req ? 3 : airborne ? 2 : move_req ? 1 : 0;
                  if (pick != m_mode || m_mode == 3) begin
                     m_mode = pick;
                     m_ticks = 0;
                  end else begin
                     m_ticks++;
                  end
               end
            end
         end
      end
   end

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("cyc_rom_addr", rom_addr, m_addr);
            chk("cyc_pix_valid", pix_valid, m_pv);
            chk("cyc_frame_idx", frame_idx, m_frame());
            chk("cyc_busy", busy, (m_mode == 3) ? 1 : 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic draw(input int x, input int y);
      draw_x = 10'(x);
      draw_y = 10'(y);
   endtask

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; move_req = 1'b0; airborne = 1'b0;
      attack_req = 1'b0; facing_left = 1'b0;
      sprite_x = 10'd100; sprite_y = 10'd50; draw_x = '0; draw_y = '0;
      repeat (3) cyc();
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_frame_idx", frame_idx, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      cyc();
      chk("rel_pix_valid", pix_valid, 0);

      // idle hit / miss / corner
      draw(100, 50); cyc();
      chk("idle_addr_origin", rom_addr, 0);
      draw(130, 50); cyc();
      chk("idle_pv_origin", pix_valid, 1);
      chk("idle_addr_miss", rom_addr, 0);
      draw(129, 72); cyc();
      chk("idle_pv_miss", pix_valid, 0);
      chk("idle_addr_corner", rom_addr, 689);
      cyc();
      chk("idle_pv_corner", pix_valid, 1);

      // walking alternates 1,2 every 8 ticks
      move_req = 1'b1;
      draw(103, 52);
      for (int t = 1; t <= 17; t++) begin
         tick();
         chk("walk_frame", frame_idx, (t <= 8 || t == 17) ? 1 : 2);
         if (t == 1) begin
            cyc();
            chk("walk_addr", rom_addr, 753);
         end
      end
      move_req = 1'b0;
      tick();
      chk("walk_stop_frame", frame_idx, 0);

      // facing latched only at a tick
      facing_left = 1'b1;
      tick();
      draw(100, 50); cyc();
      chk("mirror_addr", rom_addr, 29);
      facing_left = 1'b0;
      cyc(); cyc();
      chk("mirror_hold", rom_addr, 29);
      tick(); cyc();
      chk("mirror_release", rom_addr, 0);

      // attack while airborne, retrigger ignored, ends in jump
      airborne = 1'b1; attack_req = 1'b1;
      tick();
      attack_req = 1'b0;
      chk("atk_frame_first", frame_idx, 4);
      chk("atk_busy_first", busy, 1);
      for (int i = 2; i <= 17; i++) begin
         if (i == 3) attack_req = 1'b1;
         if (i == 13) attack_req = 1'b0;
         tick();
         chk("atk_frame", frame_idx, (i <= 8) ? 4 : (i <= 16) ? 5 : 3);
         chk("atk_busy", busy, (i <= 16) ? 1 : 0);
         if (i == 9) begin
            draw(129, 72); cyc();
            chk("atk_max_addr", rom_addr, 4139);
            sprite_x = 10'd1010; draw(5, 53); cyc();
            chk("atk_wrap_addr", rom_addr, 3559);
            sprite_x = 10'd100;
         end
      end

      // reset in the middle of an attack
      attack_req = 1'b1;
      tick();
      attack_req = 1'b0;
      draw(100, 50); cyc(); cyc();
      chk("mid_pv_before", pix_valid, 1);
      chk("mid_busy_before", busy, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_rom_addr", rom_addr, 0);
      chk("mid_rst_pix_valid", pix_valid, 0);
      chk("mid_rst_frame_idx", frame_idx, 0);
      chk("mid_rst_busy", busy, 0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_pix_valid", pix_valid, 0);
      chk("post_rst_frame_idx", frame_idx, 0);
      chk("post_rst_busy", busy, 0);
      airborne = 1'b0;
      tick();
      chk("post_rst_idle", frame_idx, 0);
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
